// File: rtl/paddle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_ctrl_if
//  Description : Control/status bundle for the paddle controller.
//                slave  : seen by paddle_ctrl (inputs are controls and
//                         geometry, outputs are position and status).
//                master : seen by whatever drives the controller.
//  Signals     : pause, recenter, move_left, move_right  - control levels
//                x_initial, screen_width, paddle_width   - geometry [POS_W]
//                x_pos                                   - paddle left edge
//                start_out, game_active, at_left, at_right - status flags
//  Revision    : 1.0 - initial release
// ============================================================================
interface paddle_ctrl_if #(
    parameter int POS_W = 10
) ();
    logic             pause;
    logic             recenter;
    logic             move_left;
    logic             move_right;
    logic [POS_W-1:0] x_initial;
    logic [POS_W-1:0] screen_width;
    logic [POS_W-1:0] paddle_width;
    logic [POS_W-1:0] x_pos;
    logic             start_out;
    logic             game_active;
    logic             at_left;
    logic             at_right;

    modport slave (
        input  pause, recenter, move_left, move_right,
        input  x_initial, screen_width, paddle_width,
        output x_pos, start_out, game_active, at_left, at_right
    );

    modport master (
        output pause, recenter, move_left, move_right,
        output x_initial, screen_width, paddle_width,
        input  x_pos, start_out, game_active, at_left, at_right
    );
endinterface
`default_nettype wire

// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_ctrl
//  Description : Paddle position controller. Moves the paddle once per
//                movement tick with acceleration on sustained presses,
//                clamps to the playfield, supports pause and recenter.
//  Ports       : clk    - system clock, all state on rising edge
//                reset  - asynchronous, active-low reset
//                bus    - paddle_ctrl_if.slave (controls, geometry, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module paddle_ctrl #(
    parameter int POS_W       = 10,
    parameter int TICK_DIV    = 100000,
    parameter int MAX_STEP    = 4,
    parameter int ACCEL_TICKS = 8
) (
    input  wire logic    clk,
    input  wire logic    reset,
    paddle_ctrl_if.slave bus
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int STEP_W = $clog2(MAX_STEP + 1);
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

    localparam logic [CNT_W-1:0]  c_TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0] c_MAX_STEP  = STEP_W'(MAX_STEP);
    localparam logic [STEP_W-1:0] c_STEP_ONE  = STEP_W'(1);
    localparam logic [HOLD_W-1:0] c_ACCEL     = HOLD_W'(ACCEL_TICKS);

    localparam logic [1:0] c_DIR_NONE  = 2'd0;
    localparam logic [1:0] c_DIR_LEFT  = 2'd1;
    localparam logic [1:0] c_DIR_RIGHT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t             r_state,  w_state_next;
    logic [POS_W-1:0]   r_x,      w_x_next;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_next;
    logic [STEP_W-1:0]  r_step,   w_step_next;
    logic [HOLD_W-1:0]  r_hold,   w_hold_next;
    logic [1:0]         r_dir,    w_dir_next;
    logic               r_start,  w_start_next;

    logic [POS_W-1:0]   w_limit;
    logic [POS_W:0]     w_cand;
    logic [POS_W:0]     w_amt;
    logic [POS_W:0]     w_x_ext;
    logic [POS_W:0]     w_step_ext;
    logic [HOLD_W-1:0]  w_hold_inc;
    logic               w_one_dir;
    logic               w_tick;
    logic [1:0]         w_req_dir;

    // A paddle wider than the field pins the left edge at 0.
    assign w_limit    = (bus.paddle_width >= bus.screen_width) ? '0
                        : bus.screen_width - bus.paddle_width;
    assign w_x_ext    = {1'b0, r_x};
    assign w_step_ext = {{(POS_W + 1 - STEP_W){1'b0}}, r_step};
    assign w_hold_inc = r_hold + 1'b1;
    assign w_one_dir  = bus.move_left ^ bus.move_right;
    assign w_req_dir  = bus.move_left ? c_DIR_LEFT : c_DIR_RIGHT;
    assign w_tick     = (r_cnt == c_TICK_LAST);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_step_next  = r_step;
        w_hold_next  = r_hold;
        w_dir_next   = r_dir;
        w_start_next = 1'b0;
        w_cand       = w_x_ext;
        w_amt        = w_step_ext;

        if (r_state == S_IDLE || bus.recenter) begin
            // Idle and recenter share the same "parked" behaviour.
            w_state_next = S_IDLE;
            w_cand       = {1'b0, bus.x_initial};
            w_cnt_next   = '0;
            w_step_next  = c_STEP_ONE;
            w_hold_next  = '0;
            w_dir_next   = c_DIR_NONE;
            if (r_state == S_IDLE && !bus.recenter && !bus.pause && w_one_dir) begin
                w_state_next = S_RUN;
                w_start_next = 1'b1;
            end
        end else if (bus.pause) begin
            w_state_next = S_PAUSED;
            w_step_next  = c_STEP_ONE;
            w_hold_next  = '0;
            w_dir_next   = c_DIR_NONE;
        end else if (r_state == S_PAUSED) begin
            // Counter stays frozen during the resume cycle.
            w_state_next = S_RUN;
        end else begin
            w_cnt_next = w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                if (w_one_dir) begin
                    w_dir_next = w_req_dir;
                    if (w_req_dir != r_dir) begin
                        // New direction (or first move): restart at one pixel.
                        w_amt       = {{POS_W{1'b0}}, 1'b1};
                        w_step_next = c_STEP_ONE;
                        w_hold_next = '0;
                    end else if (w_hold_inc == c_ACCEL) begin
                        w_hold_next = '0;
                        w_step_next = (r_step < c_MAX_STEP) ? r_step + 1'b1 : c_MAX_STEP;
                    end else begin
                        w_hold_next = w_hold_inc;
                    end
                    if (bus.move_left) begin
                        w_cand = (w_x_ext < w_amt) ? '0 : w_x_ext - w_amt;
                    end else begin
                        w_cand = w_x_ext + w_amt;
                    end
                end else begin
                    w_step_next = c_STEP_ONE;
                    w_hold_next = '0;
                    w_dir_next  = c_DIR_NONE;
                end
            end
        end

        // Final clamp also pulls the paddle in when the limit shrinks.
        w_x_next = (w_cand > {1'b0, w_limit}) ? w_limit : w_cand[POS_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_cnt   <= '0;
            r_step  <= c_STEP_ONE;
            r_hold  <= '0;
            r_dir   <= c_DIR_NONE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_x     <= w_x_next;
            r_cnt   <= w_cnt_next;
            r_step  <= w_step_next;
            r_hold  <= w_hold_next;
            r_dir   <= w_dir_next;
            r_start <= w_start_next;
        end
    end

    assign bus.x_pos       = r_x;
    assign bus.start_out   = r_start;
    assign bus.game_active = (r_state == S_RUN) || (r_state == S_PAUSED);
    assign bus.at_left     = (r_x == '0);
    assign bus.at_right    = (r_x == w_limit);

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paddle_ctrl
//  Description : Directed self-checking bench for paddle_ctrl
//                (TICK_DIV=4, MAX_STEP=3, ACCEL_TICKS=2, field 640, paddle 80).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_ctrl;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    paddle_ctrl_if #(.POS_W(10)) bus ();

    paddle_ctrl #(
        .POS_W      (10),
        .TICK_DIV   (4),
        .MAX_STEP   (3),
        .ACCEL_TICKS(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and park on the following falling edge.
    task automatic run_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.pause = 0; bus.recenter = 0; bus.move_left = 0; bus.move_right = 0;
        bus.x_initial = 10'd300; bus.screen_width = 10'd640; bus.paddle_width = 10'd80;
        #12;
        tests++; if (bus.x_pos !== 10'd0) begin fails++; $display("FAIL reset_x got %0d exp 0", bus.x_pos); end
        tests++; if (bus.start_out !== 1'b0) begin fails++; $display("FAIL reset_start got %b exp 0", bus.start_out); end
        tests++; if (bus.game_active !== 1'b0) begin fails++; $display("FAIL reset_active got %b exp 0", bus.game_active); end
        tests++; if (bus.at_left !== 1'b1) begin fails++; $display("FAIL reset_at_left got %b exp 1", bus.at_left); end
        @(negedge clk); reset = 1'b1;
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd300) begin fails++; $display("FAIL reset_release_x got %0d exp 300", bus.x_pos); end
        tests++; if (bus.game_active !== 1'b0) begin fails++; $display("FAIL reset_release_active got %b exp 0", bus.game_active); end
    endtask

    task automatic test_accel();
        int tbl [7] = '{300, 301, 302, 303, 305, 307, 310};
        int starts;
        int exp_x;
        starts = 0;
        reset = 1'b0; bus.move_right = 1'b1;
        @(negedge clk); reset = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            run_edges(1);
            if (bus.start_out === 1'b1) starts++;
            exp_x = tbl[(e - 1) / 4];
            tests++; if (bus.x_pos !== 10'(exp_x)) begin fails++; $display("FAIL accel_x edge %0d got %0d exp %0d", e, bus.x_pos, exp_x); end
            if (e == 1) begin
                tests++; if (bus.start_out !== 1'b1) begin fails++; $display("FAIL accel_start got %b exp 1", bus.start_out); end
                tests++; if (bus.game_active !== 1'b1) begin fails++; $display("FAIL accel_active got %b exp 1", bus.game_active); end
            end
        end
        tests++; if (starts != 1) begin fails++; $display("FAIL accel_start_pulses got %0d exp 1", starts); end
    endtask

    task automatic test_right_limit();
        run_edges(4 * 83);
        tests++; if (bus.x_pos !== 10'd559) begin fails++; $display("FAIL rlim_559 got %0d exp 559", bus.x_pos); end
        tests++; if (bus.at_right !== 1'b0) begin fails++; $display("FAIL rlim_at_right_early got %b exp 0", bus.at_right); end
        run_edges(4);
        tests++; if (bus.x_pos !== 10'd560) begin fails++; $display("FAIL rlim_clamp got %0d exp 560", bus.x_pos); end
        tests++; if (bus.at_right !== 1'b1) begin fails++; $display("FAIL rlim_at_right got %b exp 1", bus.at_right); end
        run_edges(4);
        tests++; if (bus.x_pos !== 10'd560) begin fails++; $display("FAIL rlim_hold got %0d exp 560", bus.x_pos); end
    endtask

    task automatic test_left_limit();
        int tbl [6] = '{8, 7, 6, 4, 2, 0};
        bus.move_right = 1'b0; bus.x_initial = 10'd9; bus.recenter = 1'b1;
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd9) begin fails++; $display("FAIL llim_recenter_x got %0d exp 9", bus.x_pos); end
        bus.recenter = 1'b0; bus.move_left = 1'b1;
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd9 || bus.start_out !== 1'b1) begin fails++; $display("FAIL llim_start got x=%0d start=%b exp x=9 start=1", bus.x_pos, bus.start_out); end
        for (int t = 0; t < 6; t++) begin
            run_edges(4);
            tests++; if (bus.x_pos !== 10'(tbl[t])) begin fails++; $display("FAIL llim_tick %0d got %0d exp %0d", t + 1, bus.x_pos, tbl[t]); end
        end
        tests++; if (bus.at_left !== 1'b1) begin fails++; $display("FAIL llim_at_left got %b exp 1", bus.at_left); end
        bus.move_right = 1'b1;
        run_edges(8);
        tests++; if (bus.x_pos !== 10'd0) begin fails++; $display("FAIL both_static got %0d exp 0", bus.x_pos); end
        bus.move_left = 1'b0;
        run_edges(4);
        tests++; if (bus.x_pos !== 10'd1) begin fails++; $display("FAIL both_then_right got %0d exp 1", bus.x_pos); end
    endtask

    task automatic test_pause();
        int tbl [6] = '{301, 302, 303, 305, 307, 310};
        bus.move_left = 0; bus.move_right = 0; bus.x_initial = 10'd300; bus.recenter = 1'b1;
        run_edges(1);
        bus.recenter = 1'b0; bus.move_right = 1'b1;
        run_edges(1);
        for (int t = 0; t < 6; t++) begin
            run_edges(4);
            tests++; if (bus.x_pos !== 10'(tbl[t])) begin fails++; $display("FAIL pause_ramp %0d got %0d exp %0d", t + 1, bus.x_pos, tbl[t]); end
        end
        run_edges(2);
        bus.pause = 1'b1;
        for (int c = 0; c < 10; c++) begin
            run_edges(1);
            tests++; if (bus.x_pos !== 10'd310 || bus.game_active !== 1'b1) begin fails++; $display("FAIL pause_frozen cyc %0d got x=%0d act=%b exp x=310 act=1", c, bus.x_pos, bus.game_active); end
        end
        bus.pause = 1'b0;
        run_edges(2);
        tests++; if (bus.x_pos !== 10'd310) begin fails++; $display("FAIL pause_resume_early got %0d exp 310", bus.x_pos); end
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd311) begin fails++; $display("FAIL pause_resume_tick got %0d exp 311", bus.x_pos); end
    endtask

    task automatic test_recenter();
        bus.move_right = 1'b0; bus.x_initial = 10'd500; bus.recenter = 1'b1;
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd500 || bus.game_active !== 1'b0) begin fails++; $display("FAIL rec_to_500 got x=%0d act=%b exp x=500 act=0", bus.x_pos, bus.game_active); end
        bus.recenter = 1'b0; bus.move_right = 1'b1;
        run_edges(1);
        bus.move_right = 1'b0;
        run_edges(2);
        tests++; if (bus.x_pos !== 10'd500 || bus.game_active !== 1'b1) begin fails++; $display("FAIL rec_run_500 got x=%0d act=%b exp x=500 act=1", bus.x_pos, bus.game_active); end
        bus.x_initial = 10'd300; bus.recenter = 1'b1;
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd300 || bus.game_active !== 1'b0 || bus.start_out !== 1'b0) begin fails++; $display("FAIL rec_idle got x=%0d act=%b start=%b exp x=300 act=0 start=0", bus.x_pos, bus.game_active, bus.start_out); end
        bus.x_initial = 10'd700;
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd560 || bus.at_right !== 1'b1) begin fails++; $display("FAIL rec_clamp_700 got x=%0d at_right=%b exp x=560 at_right=1", bus.x_pos, bus.at_right); end
        bus.recenter = 1'b0;
    endtask

    task automatic test_shrink();
        bus.x_initial = 10'd500; bus.move_right = 1'b1;
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd500 || bus.game_active !== 1'b1) begin fails++; $display("FAIL shrink_start got x=%0d act=%b exp x=500 act=1", bus.x_pos, bus.game_active); end
        bus.move_right = 1'b0; bus.screen_width = 10'd500;
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd420 || bus.at_right !== 1'b1) begin fails++; $display("FAIL shrink_420 got x=%0d at_right=%b exp x=420 at_right=1", bus.x_pos, bus.at_right); end
        bus.paddle_width = 10'd600;
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd0 || bus.at_left !== 1'b1 || bus.at_right !== 1'b1) begin fails++; $display("FAIL shrink_wide got x=%0d l=%b r=%b exp x=0 l=1 r=1", bus.x_pos, bus.at_left, bus.at_right); end
        bus.screen_width = 10'd640; bus.paddle_width = 10'd80;
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd0 || bus.at_right !== 1'b0) begin fails++; $display("FAIL shrink_restore got x=%0d r=%b exp x=0 r=0", bus.x_pos, bus.at_right); end
    endtask

    task automatic test_reset_mid();
        bus.x_initial = 10'd400; bus.recenter = 1'b1;
        run_edges(1);
        bus.recenter = 1'b0; bus.move_right = 1'b1;
        run_edges(3);
        tests++; if (bus.x_pos !== 10'd400 || bus.game_active !== 1'b1) begin fails++; $display("FAIL rmid_pre got x=%0d act=%b exp x=400 act=1", bus.x_pos, bus.game_active); end
        #2 reset = 1'b0;
        #1;
        tests++; if (bus.x_pos !== 10'd0 || bus.game_active !== 1'b0) begin fails++; $display("FAIL rmid_async got x=%0d act=%b exp x=0 act=0", bus.x_pos, bus.game_active); end
        bus.x_initial = 10'd300; bus.move_right = 1'b0;
        @(negedge clk); reset = 1'b1;
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd300 || bus.game_active !== 1'b0) begin fails++; $display("FAIL rmid_release got x=%0d act=%b exp x=300 act=0", bus.x_pos, bus.game_active); end
        bus.move_right = 1'b1;
        run_edges(1);
        tests++; if (bus.start_out !== 1'b1) begin fails++; $display("FAIL rmid_restart got %b exp 1", bus.start_out); end
        run_edges(3);
        tests++; if (bus.x_pos !== 10'd300) begin fails++; $display("FAIL rmid_no_tick got %0d exp 300", bus.x_pos); end
        run_edges(1);
        tests++; if (bus.x_pos !== 10'd301) begin fails++; $display("FAIL rmid_first_tick got %0d exp 301", bus.x_pos); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_accel();
        test_right_limit();
        test_left_limit();
        test_pause();
        test_recenter();
        test_shrink();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameter POS_W, default 10, width of all position/size ports.
REQ-002 SHALL have parameter TICK_DIV, default 100000, clk cycles per movement tick (>=2).
REQ-003 SHALL have parameter MAX_STEP, default 4, maximum pixels moved per tick (>=1).
REQ-004 SHALL have parameter ACCEL_TICKS, default 8, consecutive same-direction ticks before step increases (>=1).
REQ-005 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port pause  input  1  freeze movement while high.
REQ-008 SHALL have port recenter  input  1  return to idle and initial position.
REQ-009 SHALL have port move_left  input  1  level request to move left.
REQ-010 SHALL have port move_right  input  1  level request to move right.
REQ-011 SHALL have port x_initial  input  POS_W  start position.
REQ-012 SHALL have port screen_width  input  POS_W  playfield width.
REQ-013 SHALL have port paddle_width  input  POS_W  paddle width.
REQ-014 SHALL have port x_pos  output  POS_W  registered paddle left-edge position.
REQ-015 SHALL have port start_out  output  1  one-cycle pulse on game start.
REQ-016 SHALL have port game_active  output  1  high in RUN or PAUSED.
REQ-017 SHALL have port at_left / at_right  output  1 each  x_pos equals 0 / right_limit (combinational from x_pos).

Function
REQ-018 right_limit SHALL be screen_width - paddle_width, or 0 when paddle_width >= screen_width.
REQ-019 clamp(v) SHALL be min(v, right_limit); all position arithmetic SHALL use POS_W+1 bits, no wrap-around.
REQ-020 FSM states SHALL be IDLE, RUN, PAUSED; priority per cycle: recenter > pause > movement.
REQ-021 IDLE: x_pos SHALL load clamp(x_initial) every cycle; tick counter, step and hold counter held at 0/1/0.
REQ-022 IDLE->RUN SHALL occur when exactly one of move_left/move_right is high and pause and recenter are low; start_out high that cycle only; no position change that cycle; tick counter cleared.
REQ-023 RUN: tick counter SHALL count 0..TICK_DIV-1 and wrap; tick asserted in the cycle the count equals TICK_DIV-1.
REQ-024 On tick with move_left only: x_pos <= (x_pos < step) ? 0 : x_pos - step.
REQ-025 On tick with move_right only: x_pos <= clamp(x_pos + step).
REQ-026 On tick with both or neither pressed: x_pos unchanged, step <= 1, hold <= 0.
REQ-027 Acceleration: on tick with same direction as previous tick, hold increments; when hold reaches ACCEL_TICKS, step <= min(step+1, MAX_STEP), hold <= 0.
REQ-028 Direction change on a tick SHALL move by 1, set step <= 1, hold <= 0.
REQ-029 RUN->PAUSED when pause high; tick counter and x_pos frozen; step <= 1, hold <= 0.
REQ-030 PAUSED->RUN when pause low; tick counter resumes from frozen value.
REQ-031 recenter high in any state SHALL go to IDLE next cycle with x_pos <= clamp(x_initial); no start_out pulse.
REQ-032 If right_limit drops below x_pos in RUN/PAUSED, x_pos SHALL be clamped to right_limit next cycle regardless of tick.

Reset
REQ-033 reset low SHALL asynchronously force state IDLE, x_pos 0, start_out 0, game_active 0, tick counter 0, step 1, hold 0.
REQ-034 After reset release, x_pos SHALL equal clamp(x_initial) from the first clock edge onward.
REQ-035 reset asserted mid-RUN or mid-PAUSED SHALL behave as REQ-033 with no residual state.

Verification (TICK_DIV=4, MAX_STEP=3, ACCEL_TICKS=2, screen 640, paddle 80, x_initial 300)
REQ-036 Release reset, hold move_right -> start_out one pulse, x_pos 300,301(tick1),302,303(step 2),305,307(step 3),310 every 4 cycles.
REQ-037 x_pos 559, right held with step 3 -> x_pos 560, at_right high, no overflow.
REQ-038 x_pos 2 moving left step 3 -> x_pos 0, at_left high; both buttons pressed -> x_pos static, step 1.
REQ-039 pause mid-count (counter 2) for 10 cycles -> x_pos frozen, game_active high; release -> next tick 2 cycles later, step 1.
REQ-040 recenter in RUN at x_pos 500 -> IDLE, x_pos 300, game_active 0; x_initial 700 -> x_pos 560.
REQ-041 reset low mid-RUN between edges -> x_pos 0 immediately, then 300 on first edge after release.
